// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1331 96x64 OLED sequencer.
// Pixel colour bytes are RRRGGGBB: red [7:5], green [4:2], blue [1:0].
package oled_pkg;

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    INIT,
    WIN,
    PIX,
    FRAME_END,
    IDLE
  } state_t;

  localparam int INIT_LEN = 37;
  localparam int WIN_LEN  = 6;

  localparam logic [7:0] CMD_SETCOL = 8'h15;
  localparam logic [7:0] CMD_SETROW = 8'h75;

  // Power-up command list; the leftmost byte is index 0.
  localparam logic [0:INIT_LEN-1][7:0] INIT_ROM = {
    8'hAE,
    8'hA0, 8'h22,
    8'hA1, 8'h00,
    8'hA2, 8'h00,
    8'hA4,
    8'hA8, 8'h3F,
    8'hAD, 8'h8E,
    8'hB0, 8'h0B,
    8'hB1, 8'h31,
    8'hB3, 8'hF0,
    8'h8A, 8'h64,
    8'h8B, 8'h78,
    8'h8C, 8'h64,
    8'hBB, 8'h3A,
    8'hBE, 8'h3E,
    8'h87, 8'h06,
    8'h81, 8'h91,
    8'h82, 8'h50,
    8'h83, 8'h7D,
    8'hAF
  };

  // Column/row window covering the whole panel, sent before every frame.
  function automatic logic [7:0] win_byte(input logic [2:0] idx, input int width,
                                          input int height);
    case (idx)
      3'd0:    win_byte = CMD_SETCOL;
      3'd1:    win_byte = 8'h00;
      3'd2:    win_byte = 8'(width - 1);
      3'd3:    win_byte = CMD_SETROW;
      3'd4:    win_byte = 8'h00;
      3'd5:    win_byte = 8'(height - 1);
      default: win_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/oled_init_rom.sv
// Init command lookup: index -> byte, 0x00 past the end of the list.
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [5:0] idx,
  output logic [7:0] data
);

  always_comb begin
    // NOTE: assign a default first so every path drives data and no latch is inferred.
    data = 8'h00;
    if (idx < 6'(INIT_LEN)) data = INIT_ROM[idx];
  end

endmodule

// File: rtl/oled_seq.sv
// SSD1331 sequencer: panel reset, init command stream, then per-frame
// window commands followed by WIDTH*HEIGHT pixel bytes over valid/ready.
module oled_seq
  import oled_pkg::*;
#(
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 64,
  parameter int RESET_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  output logic       oled_resn,
  output logic [7:0] x,
  output logic [5:0] y,
  input  logic [7:0] color,
  output logic       init_done,
  output logic       frame_done
);

  localparam int              CW       = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]   RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [7:0]      X_LAST   = 8'(WIDTH - 1);
  localparam logic [5:0]      Y_LAST   = 6'(HEIGHT - 1);
  localparam logic [5:0]      ROM_END  = 6'(INIT_LEN);
  localparam logic [2:0]      WIN_END  = 3'(WIN_LEN);

  state_t        state;
  logic [CW-1:0] rst_cnt;
  logic [5:0]    rom_idx;
  logic [2:0]    win_idx;
  logic [7:0]    cmd_byte;
  logic [7:0]    rom_data;

  // rom_idx always points at the next byte to load.
  oled_init_rom u_init_rom (
    .idx  (rom_idx),
    .data (rom_data)
  );

  // Pixel bytes come straight from the colour input so the byte for the
  // freshly advanced x/y is ready in the cycle right after an accept.
  assign tx_data = (state == PIX) ? color : cmd_byte;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= RST_LO;
      rst_cnt    <= '0;
      rom_idx    <= '0;
      win_idx    <= '0;
      cmd_byte   <= '0;
      tx_valid   <= 1'b0;
      tx_dc      <= 1'b0;
      oled_resn  <= 1'b0;
      x          <= '0;
      y          <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        RST_LO: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt   <= '0;
            oled_resn <= 1'b1;
            state     <= RST_HI;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RST_HI: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt <= '0;
            state   <= INIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        INIT: begin
          if (!tx_valid) begin
            cmd_byte <= rom_data;
            rom_idx  <= rom_idx + 6'd1;
            tx_dc    <= 1'b0;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            if (rom_idx == ROM_END) begin
              tx_valid  <= 1'b0;
              rom_idx   <= '0;
              init_done <= 1'b1;
              state     <= enable ? WIN : IDLE;
            end else begin
              cmd_byte <= rom_data;
              rom_idx  <= rom_idx + 6'd1;
            end
          end
        end
        WIN: begin
          if (!tx_valid) begin
            cmd_byte <= win_byte(win_idx, WIDTH, HEIGHT);
            win_idx  <= win_idx + 3'd1;
            tx_dc    <= 1'b0;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            if (win_idx == WIN_END) begin
              tx_valid <= 1'b0;
              win_idx  <= '0;
              x        <= '0;
              y        <= '0;
              state    <= PIX;
            end else begin
              cmd_byte <= win_byte(win_idx, WIDTH, HEIGHT);
              win_idx  <= win_idx + 3'd1;
            end
          end
        end
        PIX: begin
          if (!tx_valid) begin
            tx_dc    <= 1'b1;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y          <= '0;
                tx_valid   <= 1'b0;
                tx_dc      <= 1'b0;
                frame_done <= 1'b1;
                state      <= FRAME_END;
              end else begin
                y <= y + 6'd1;
              end
            end else begin
              x <= x + 8'd1;
            end
          end
        end
        FRAME_END: state <= enable ? WIN : IDLE;
        IDLE:      if (enable) state <= WIN;
        default:   state <= RST_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_seq.sv
// Scoreboard bench for oled_seq: a byte-stream model fills a queue and a
// negedge monitor pops and compares on every accepted byte.
module tb_oled_seq;

  localparam int W    = 96;
  localparam int H    = 64;
  localparam int RC   = 4;
  localparam int NPIX = W * H;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       enable   = 1'b1;
  logic       tx_ready = 1'b1;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       oled_resn;
  logic [7:0] x;
  logic [5:0] y;
  logic [7:0] color;
  logic       init_done;
  logic       frame_done;

  always #5 clk = ~clk;

  // Pixel generator: colour is a plain function of the coordinates.
  assign color = x ^ {y, 2'b00};

  oled_seq #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .RESET_CYCLES (RC)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_dc      (tx_dc),
    .oled_resn  (oled_resn),
    .x          (x),
    .y          (y),
    .color      (color),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       pix;
    logic [7:0] ex;
    logic [5:0] ey;
    int         frame;
    int         k;
    logic       last;
    logic       in_init;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks      = 0;
  int errors      = 0;
  int mon_frame   = 0;
  int mon_pix     = 0;
  int frames_seen = 0;
  logic fd_due  = 1'b0;
  logic stall   = 1'b0;
  logic bp_mode = 1'b0;
  logic [7:0] s_data;
  logic [7:0] s_x;
  logic [5:0] s_y;
  logic       s_dc;

  int init_list [37] = '{
    'hAE, 'hA0, 'h22, 'hA1, 'h00, 'hA2, 'h00, 'hA4, 'hA8, 'h3F,
    'hAD, 'h8E, 'hB0, 'h0B, 'hB1, 'h31, 'hB3, 'hF0, 'h8A, 'h64,
    'h8B, 'h78, 'h8C, 'h64, 'hBB, 'h3A, 'hBE, 'h3E, 'h87, 'h06,
    'h81, 'h91, 'h82, 'h50, 'h83, 'h7D, 'hAF
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic dc, input int frame);
    exp_t e;
    e.data = d; e.dc = dc; e.pix = 1'b0; e.ex = '0; e.ey = '0;
    e.frame = frame; e.k = 0; e.last = 1'b0; e.in_init = 1'b0;
    return e;
  endfunction

  task automatic push_init();
    exp_t e;
    for (int i = 0; i < 37; i++) begin
      e = mk(8'(init_list[i]), 1'b0, 0);
      e.in_init = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic push_frame(input int f);
    exp_t e;
    int   win [6];
    win = '{'h15, 'h00, W - 1, 'h75, 'h00, H - 1};
    for (int i = 0; i < 6; i++) sb.push_back(mk(8'(win[i]), 1'b0, f));
    for (int k = 0; k < NPIX; k++) begin
      e      = mk(8'((k % W) ^ ((k / W) * 4)), 1'b1, f);
      e.pix  = 1'b1;
      e.ex   = 8'(k % W);
      e.ey   = 6'(k / W);
      e.k    = k;
      e.last = (k == NPIX - 1);
      sb.push_back(e);
    end
  endtask

  // Ready driver: always-ready or roughly 30% ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: compare accepted bytes, hold-stability under stall, frame_done pulses.
  always @(negedge clk) begin
    if (!resetn) begin
      fd_due = 1'b0;
      stall  = 1'b0;
    end else begin
      check("frame_done", frame_done, fd_due);
      if (fd_due) begin
        frames_seen++;
        check("frame_end_x", x, 0);
        check("frame_end_y", y, 0);
      end
      fd_due = 1'b0;
      if (stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, s_data);
        check("hold_dc", tx_dc, s_dc);
        check("hold_x", x, s_x);
        check("hold_y", y, s_y);
      end
      if (tx_valid && tx_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("tx_data", tx_data, mon_e.data);
          check("tx_dc", tx_dc, mon_e.dc);
          check("init_done", init_done, !mon_e.in_init);
          if (mon_e.pix) begin
            check("x", x, mon_e.ex);
            check("y", y, mon_e.ey);
            mon_pix = mon_e.k + 1;
          end else begin
            mon_pix = 0;
          end
          mon_frame = mon_e.frame;
          if (mon_e.last) fd_due = 1'b1;
        end
      end
      stall  = tx_valid && !tx_ready;
      s_data = tx_data;
      s_dc   = tx_dc;
      s_x    = x;
      s_y    = y;
    end
  end

  task automatic check_reset_vals();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_dc", tx_dc, 0);
    check("rst_oled_resn", oled_resn, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_init_done", init_done, 0);
    check("rst_frame_done", frame_done, 0);
  endtask

  task automatic release_and_time();
    int n;
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (!oled_resn && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("resn_low_cycles", n, RC);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("first_valid_delay", n, RC + 1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int i = 0;
    while (frames_seen < target && i < budget) begin
      @(negedge clk); i++;
    end
    check("wait_frames", 32'(frames_seen >= target), 1);
  endtask

  task automatic wait_pix(input int f, input int cnt, input int budget);
    int i = 0;
    while (!(mon_frame == f && mon_pix >= cnt) && i < budget) begin
      @(negedge clk); i++;
    end
    check("wait_pix", 32'(mon_frame == f && mon_pix >= cnt), 1);
  endtask

  task automatic wait_init(input int budget);
    int i = 0;
    while (!init_done && i < budget) begin
      @(negedge clk); i++;
    end
    check("wait_init", init_done, 1);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_valid", tx_valid, 0);
    end
  endtask

  initial begin
    resetn  = 1'b0;
    enable  = 1'b1;
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();

    // Init plus two free-running frames, then a backpressured third frame
    // during which enable drops at pixel 100.
    push_init();
    push_frame(1);
    push_frame(2);
    push_frame(3);
    release_and_time();
    wait_frames(2, 20000);
    bp_mode = 1'b1;
    wait_pix(3, 100, 2000);
    enable = 1'b0;
    wait_frames(3, 40000);
    bp_mode = 1'b0;
    idle_check(20);
    check("sb_drained_idle", sb.size(), 0);

    // Restart from IDLE, then reset in the middle of the pixel stream.
    push_frame(4);
    enable = 1'b1;
    wait_pix(4, 3000, 10000);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Full bring-up again with enable low: init then stay idle.
    push_init();
    release_and_time();
    wait_init(200);
    idle_check(20);
    check("sb_drained_init", sb.size(), 0);

    // One more frame from IDLE; enable drops once it is under way.
    push_frame(5);
    enable = 1'b1;
    wait_pix(5, 1, 200);
    enable = 1'b0;
    wait_frames(4, 10000);
    idle_check(10);
    check("sb_drained_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
